control_unit: RTL



---
 rtl/cpu_pkg.sv | 55 +++++
 rtl/control_decode.sv | 39 +++
 rtl/control_unit.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the single-bus CPU control path: opcode
// constants, IR field positions, sequencer state and instruction class.
package cpu_pkg;

    // 5-bit opcodes carried in IR[31:27]
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHL  = 5'b01000;
    localparam logic [4:0] OP_ROR  = 5'b01001;
    localparam logic [4:0] OP_ROL  = 5'b01010;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // IR field bit positions
    localparam int OPC_HI = 31;
    localparam int OPC_LO = 27;
    localparam int RA_HI  = 26;
    localparam int RA_LO  = 23;
    localparam int RB_HI  = 22;
    localparam int RB_LO  = 19;
    localparam int RC_HI  = 18;
    localparam int RC_LO  = 15;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_T0     = 4'd1,
        S_T1     = 4'd2,
        S_T2     = 4'd3,
        S_T3     = 4'd4,
        S_T4     = 4'd5,
        S_T5     = 4'd6,
        S_T6     = 4'd7,
        S_HALTED = 4'd8
    } state_t;

    typedef enum logic [2:0] {
        IC_NOP    = 3'd0,
        IC_ALU3   = 3'd1,
        IC_ALU2   = 3'd2,
        IC_MULDIV = 3'd3,
        IC_HALT   = 3'd4
    } iclass_t;

    function automatic logic [4:0] ir_opcode(input logic [31:0] ir);
        return ir[OPC_HI:OPC_LO];
    endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational opcode classifier for the control sequencer.
// Ports: opcode (in, 5) -> iclass (out, instruction class).
// CONTROL_UNIT_MULDIV_EN: when undefined, MUL/DIV classify as NOP.
module control_decode
    import cpu_pkg::*;
(
    input  logic [4:0] opcode,
    output iclass_t    iclass
);

    logic is_alu3;
    logic is_alu2;
    logic is_md;
    logic is_halt;

    assign is_alu3 = opcode inside {OP_ADD, OP_SUB, OP_AND, OP_OR,
                                    OP_SHR, OP_SHL, OP_ROR, OP_ROL};
    assign is_alu2 = opcode inside {OP_NEG, OP_NOT};
    assign is_halt = (opcode == OP_HALT);

`ifdef CONTROL_UNIT_MULDIV_EN
    assign is_md = opcode inside {OP_MUL, OP_DIV};
`else
    assign is_md = 1'b0;
`endif

    // Undefined opcodes (and OP_NOP) fall through to NOP
    always_comb begin
        iclass = IC_NOP;
        unique case (1'b1)
            is_alu3: iclass = IC_ALU3;
            is_alu2: iclass = IC_ALU2;
            is_md:   iclass = IC_MULDIV;
            is_halt: iclass = IC_HALT;
            default: iclass = IC_NOP;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired fetch/execute sequencer for the single-bus CPU datapath.
// Inputs: clk, rst_n (async low), run, IR_Data[31:0], mem_ready.
// Outputs: bus selects, register enables, read, Gra/Grb/Grc,
// alu_instruction[4:0], halted, state[3:0].
// CONTROL_UNIT_MULDIV_EN: enables the MUL/DIV T3-T6 sequence and
// drives HI_enable/LO_enable; otherwise MUL/DIV execute as NOP.
module control_unit
    import cpu_pkg::*;
#(
    parameter int RESET_PC_INC = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [31:0] IR_Data,
    input  logic        mem_ready,
    output logic        PC_select,
    output logic        Z_LO_select,
    output logic        Z_HI_select,
    output logic        MDR_select,
    output logic        Rout,
    output logic        PC_enable,
    output logic        PC_increment_enable,
    output logic        IR_enable,
    output logic        Y_enable,
    output logic        Z_enable,
    output logic        MAR_enable,
    output logic        MDR_enable,
    output logic        HI_enable,
    output logic        LO_enable,
    output logic        Rin,
    output logic        read,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic [4:0]  alu_instruction,
    output logic        halted,
    output logic [3:0]  state
);

    state_t     st;
    state_t     st_end;
    iclass_t    iclass;
    logic [4:0] opcode;
    logic       cfg_unused;

    assign opcode = ir_opcode(IR_Data);

    // Register fields are decoded by the datapath, not here
    assign cfg_unused = ^IR_Data[RA_HI:0] ^ (RESET_PC_INC != 1);

    control_decode u_decode (
        .opcode (opcode),
        .iclass (iclass)
    );

    // run is only looked at when an instruction finishes
    assign st_end = run ? S_T0 : S_IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st <= S_IDLE;
        end else begin
            unique case (st)
                S_IDLE:   st <= run ? S_T0 : S_IDLE;
                S_T0:     st <= S_T1;
                S_T1:     st <= mem_ready ? S_T2 : S_T1;
                S_T2:     st <= S_T3;
                S_T3: begin
                    unique case (iclass)
                        IC_ALU3,
                        IC_ALU2,
                        IC_MULDIV: st <= S_T4;
                        IC_HALT:   st <= S_HALTED;
                        default:   st <= st_end;
                    endcase
                end
                S_T4: begin
                    unique case (iclass)
                        IC_ALU3,
                        IC_MULDIV: st <= S_T5;
                        default:   st <= st_end;
                    endcase
                end
                S_T5:     st <= (iclass == IC_MULDIV) ? S_T6 : st_end;
                S_T6:     st <= st_end;
                S_HALTED: st <= run ? S_HALTED : S_IDLE;
                default:  st <= S_IDLE;
            endcase
        end
    end

    assign state  = st;
    assign halted = (st == S_HALTED);

    // Moore decode of the current step; PC_enable in T1 is the
    // single exception, gated by mem_ready so PC loads once.
    always_comb begin
        PC_select           = 1'b0;
        Z_LO_select         = 1'b0;
        Z_HI_select         = 1'b0;
        MDR_select          = 1'b0;
        Rout                = 1'b0;
        PC_enable           = 1'b0;
        PC_increment_enable = 1'b0;
        IR_enable           = 1'b0;
        Y_enable            = 1'b0;
        Z_enable            = 1'b0;
        MAR_enable          = 1'b0;
        MDR_enable          = 1'b0;
        HI_enable           = 1'b0;
        LO_enable           = 1'b0;
        Rin                 = 1'b0;
        read                = 1'b0;
        Gra                 = 1'b0;
        Grb                 = 1'b0;
        Grc                 = 1'b0;
        alu_instruction     = 5'd0;
        unique case (st)
            S_T0: begin
                PC_select           = 1'b1;
                MAR_enable          = 1'b1;
                PC_increment_enable = 1'b1;
                Z_enable            = 1'b1;
            end
            S_T1: begin
                Z_LO_select = 1'b1;
                read        = 1'b1;
                MDR_enable  = 1'b1;
                PC_enable   = mem_ready;
            end
            S_T2: begin
                MDR_select = 1'b1;
                IR_enable  = 1'b1;
            end
            S_T3: begin
                unique case (iclass)
                    IC_ALU3: begin
                        Grb      = 1'b1;
                        Rout     = 1'b1;
                        Y_enable = 1'b1;
                    end
                    IC_ALU2: begin
                        Grb             = 1'b1;
                        Rout            = 1'b1;
                        Z_enable        = 1'b1;
                        alu_instruction = opcode;
                    end
                    IC_MULDIV: begin
                        Gra      = 1'b1;
                        Rout     = 1'b1;
                        Y_enable = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T4: begin
                unique case (iclass)
                    IC_ALU3: begin
                        Grc             = 1'b1;
                        Rout            = 1'b1;
                        Z_enable        = 1'b1;
                        alu_instruction = opcode;
                    end
                    IC_ALU2: begin
                        Z_LO_select = 1'b1;
                        Gra         = 1'b1;
                        Rin         = 1'b1;
                    end
                    IC_MULDIV: begin
                        Grb             = 1'b1;
                        Rout            = 1'b1;
                        Z_enable        = 1'b1;
                        alu_instruction = opcode;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                unique case (iclass)
                    IC_ALU3: begin
                        Z_LO_select = 1'b1;
                        Gra         = 1'b1;
                        Rin         = 1'b1;
                    end
                    IC_MULDIV: begin
                        Z_LO_select = 1'b1;
`ifdef CONTROL_UNIT_MULDIV_EN
                        LO_enable   = 1'b1;
`endif
                    end
                    default: ;
                endcase
            end
            S_T6: begin
                Z_HI_select = 1'b1;
`ifdef CONTROL_UNIT_MULDIV_EN
                HI_enable   = 1'b1;
`endif
            end
            default: ;
        endcase
    end

endmodule
